// File: rtl/line_wr_arbiter_pkg.sv
// Shared types and defaults for the line-memory write arbiter.
package line_wr_arbiter_pkg;

   localparam int DEF_LINE_W    = 480;
   localparam int DEF_ADDR_W    = 10;
   localparam int DEF_NUM_LINES = 640;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_GRANT
   } state_t;

   typedef enum logic {
      REQ_FALL  = 1'b0,
      REQ_BEGIN = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: bit 0 = fall, bit 1 = begin; output is one-hot or zero.
module rr_pick2
   import line_wr_arbiter_pkg::*;
(
   input  logic [1:0] elig,
   input  req_id_t    last,
   output logic [1:0] grant
);

   always_comb begin
      grant = elig;
      // contested: favour whoever did not win last time
      if (elig == 2'b11)
         grant = (last == REQ_BEGIN) ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/line_wr_arbiter.sv
// Arbitrates the line RAM write port between the fall and start-screen writers,
// with a zero-fill sweep after reset or on clr_start.
module line_wr_arbiter
   import line_wr_arbiter_pkg::*;
#(
   parameter int LINE_W    = DEF_LINE_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int NUM_LINES = DEF_NUM_LINES
) (
   input  logic              clk,
   input  logic              clk_rst,
   input  logic              fall_req,
   input  logic [ADDR_W-1:0] fall_addr,
   input  logic [LINE_W-1:0] fall_data,
   output logic              fall_ack,
   input  logic              begin_req,
   input  logic [ADDR_W-1:0] begin_addr,
   input  logic [LINE_W-1:0] begin_data,
   output logic              begin_ack,
   input  logic              clr_start,
   output logic              clr_busy,
   input  logic [ADDR_W-1:0] h_addr,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [LINE_W-1:0] mem_wdata
);

   localparam logic [ADDR_W:0] CNT_END = NUM_LINES[ADDR_W:0];

   state_t            state;
   req_id_t           last;
   logic [ADDR_W:0]   clr_cnt;
   logic [1:0]        elig;
   logic [1:0]        grant;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_data;
   logic              sel_in_range;

   assign elig[0] = fall_req  && (fall_addr  != h_addr);
   assign elig[1] = begin_req && (begin_addr != h_addr);

   rr_pick2 u_pick (
      .elig  (elig),
      .last  (last),
      .grant (grant)
   );

   always_comb begin
      sel_addr     = grant[1] ? begin_addr : fall_addr;
      sel_data     = grant[1] ? begin_data : fall_data;
      sel_in_range = ({1'b0, sel_addr} < CNT_END);
   end

   always_ff @(posedge clk or posedge clk_rst) begin
      if (clk_rst) begin
         state     <= ST_CLEAR;
         last      <= REQ_BEGIN;
         clr_cnt   <= '0;
         clr_busy  <= 1'b1;
         mem_wren  <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         fall_ack  <= 1'b0;
         begin_ack <= 1'b0;
      end else begin
         fall_ack  <= 1'b0;
         begin_ack <= 1'b0;
         mem_wren  <= 1'b0;
         case (state)
            ST_CLEAR: begin
               if (clr_start) begin
                  // restart writes address 0 right away; counter moves past it
                  mem_wren  <= 1'b1;
                  mem_waddr <= '0;
                  mem_wdata <= '0;
                  clr_cnt   <= {{ADDR_W{1'b0}}, 1'b1};
               end else if (clr_cnt == CNT_END) begin
                  state    <= ST_IDLE;
                  clr_busy <= 1'b0;
               end else begin
                  mem_wren  <= 1'b1;
                  mem_waddr <= clr_cnt[ADDR_W-1:0];
                  mem_wdata <= '0;
                  clr_cnt   <= clr_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (clr_start) begin
                  state    <= ST_CLEAR;
                  clr_cnt  <= '0;
                  clr_busy <= 1'b1;
               end else if (grant != 2'b00) begin
                  state     <= ST_GRANT;
                  mem_wren  <= sel_in_range;
                  mem_waddr <= sel_addr;
                  mem_wdata <= sel_data;
                  fall_ack  <= grant[0];
                  begin_ack <= grant[1];
                  last      <= grant[1] ? REQ_BEGIN : REQ_FALL;
               end
            end
            ST_GRANT: begin
               if (clr_start) begin
                  state    <= ST_CLEAR;
                  clr_cnt  <= '0;
                  clr_busy <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_line_wr_arbiter.sv
// Directed bench for line_wr_arbiter: sweeps, round-robin, collision, drop and restart cases.
module tb_line_wr_arbiter;

   localparam int LINE_W    = 480;
   localparam int ADDR_W    = 10;
   localparam int NUM_LINES = 640;

   localparam logic [LINE_W-1:0] DA = {15{32'hA5A5_0F0F}};
   localparam logic [LINE_W-1:0] DB = {15{32'h1234_5678}};
   localparam logic [LINE_W-1:0] DC = {15{32'hDEAD_BEEF}};

   logic              clk = 1'b0;
   logic              clk_rst;
   logic              fall_req, begin_req, clr_start;
   logic [ADDR_W-1:0] fall_addr, begin_addr, h_addr;
   logic [LINE_W-1:0] fall_data, begin_data;
   logic              fall_ack, begin_ack, clr_busy, mem_wren;
   logic [ADDR_W-1:0] mem_waddr;
   logic [LINE_W-1:0] mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   line_wr_arbiter #(
      .LINE_W    (LINE_W),
      .ADDR_W    (ADDR_W),
      .NUM_LINES (NUM_LINES)
   ) dut (
      .clk        (clk),
      .clk_rst    (clk_rst),
      .fall_req   (fall_req),
      .fall_addr  (fall_addr),
      .fall_data  (fall_data),
      .fall_ack   (fall_ack),
      .begin_req  (begin_req),
      .begin_addr (begin_addr),
      .begin_data (begin_data),
      .begin_ack  (begin_ack),
      .clr_start  (clr_start),
      .clr_busy   (clr_busy),
      .h_addr     (h_addr),
      .mem_wren   (mem_wren),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata)
   );

   always #5 clk = ~clk;

   // {mem_wren, fall_ack, begin_ack, clr_busy}
   function automatic logic [3:0] ctl();
      return {mem_wren, fall_ack, begin_ack, clr_busy};
   endfunction

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_sweep_cycle(input string tag, input int i);
      @(negedge clk);
      check(tag, {mem_wdata, mem_waddr, ctl()}, {{LINE_W{1'b0}}, ADDR_W'(i), 4'b1001});
   endtask

   task automatic expect_sweep(input string tag);
      for (int i = 0; i < NUM_LINES; i++)
         check_sweep_cycle(tag, i);
      @(negedge clk);
      check({tag, "_end"}, ctl(), 4'b0000);
   endtask

   task automatic check_write(input string tag, input logic [3:0] c,
                              input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      check(tag, {mem_wdata, mem_waddr, ctl()}, {d, a, c});
   endtask

   initial begin
      clk_rst    = 1'b1;
      clr_start  = 1'b0;
      h_addr     = 10'd100;
      fall_req   = 1'b1;
      fall_addr  = 10'd10;
      fall_data  = DA;
      begin_req  = 1'b1;
      begin_addr = 10'd20;
      begin_data = DB;

      repeat (3) @(negedge clk);
      check("rst_ctl", ctl(), 4'b0001);
      check("rst_wr", {mem_wdata, mem_waddr}, '0);

      // both requests held through the reset sweep; neither may be acked
      clk_rst = 1'b0;
      expect_sweep("sweep0");

      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k % 2 == 0)
            check_write("rr_fall", 4'b1100, 10'd10, DA);
         else
            check_write("rr_begin", 4'b1010, 10'd20, DB);
         if (k < 3) begin
            @(negedge clk);
            check("rr_idle", ctl(), 4'b0000);
         end
      end
      fall_req  = 1'b0;
      begin_req = 1'b0;

      @(negedge clk);
      fall_req  = 1'b1;
      fall_addr = 10'd37;
      fall_data = '1;
      @(negedge clk);
      check_write("single", 4'b1100, 10'd37, '1);
      fall_req = 1'b0;
      @(negedge clk);
      check("single_after", ctl(), 4'b0000);

      begin_req  = 1'b1;
      begin_addr = 10'd200;
      begin_data = DC;
      h_addr     = 10'd200;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("collide_wait", ctl(), 4'b0000);
      end
      h_addr = 10'd201;
      @(negedge clk);
      check_write("collide_go", 4'b1010, 10'd200, DC);
      begin_req = 1'b0;
      @(negedge clk);
      check("collide_after", ctl(), 4'b0000);

      fall_req  = 1'b1;
      fall_addr = 10'd700;
      fall_data = DA;
      h_addr    = 10'd0;
      @(negedge clk);
      check("oor_drop", ctl(), 4'b0100);
      fall_req = 1'b0;
      @(negedge clk);
      check("oor_after", ctl(), 4'b0000);

      clr_start = 1'b1;
      @(posedge clk);
      #1 clr_start = 1'b0;
      @(negedge clk);
      check("clr_enter", ctl(), 4'b0001);
      for (int i = 0; i <= 300; i++)
         check_sweep_cycle("sweep1", i);
      clr_start = 1'b1;
      @(posedge clk);
      #1 clr_start = 1'b0;
      expect_sweep("sweep_restart");

      fall_req  = 1'b1;
      fall_addr = 10'd3;
      fall_data = DB;
      @(negedge clk);
      check_write("grant_clr_wr", 4'b1100, 10'd3, DB);
      fall_req  = 1'b0;
      clr_start = 1'b1;
      @(posedge clk);
      #1 clr_start = 1'b0;
      @(negedge clk);
      check("grant_clr_enter", ctl(), 4'b0001);
      expect_sweep("sweep_grant");

      fall_req  = 1'b1;
      fall_addr = 10'd9;
      fall_data = DC;
      @(negedge clk);
      check_write("midrst_wr", 4'b1100, 10'd9, DC);
      clk_rst = 1'b1;
      #1;
      check("midrst_ctl", ctl(), 4'b0001);
      check("midrst_wr", {mem_wdata, mem_waddr}, '0);
      fall_req = 1'b0;
      @(negedge clk);
      clk_rst = 1'b0;
      check_sweep_cycle("midrst_sweep", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
